// File: rtl/nmea_frame_ctrl.sv
// nmea_frame_ctrl: frames NMEA sentences, streams fields, checks the XOR checksum and acknowledges GLL sentences over the UART transmitter
module nmea_frame_ctrl #(
   parameter int MAX_LEN    = 82,
   parameter int MAX_FIELDS = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_dv,
   input  logic [7:0] rx_byte,
   output logic       fld_dv,
   output logic [7:0] fld_char,
   output logic [3:0] fld_idx,
   output logic       fld_end,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       tx_dv,
   output logic [7:0] tx_byte,
   input  logic       tx_active,
   input  logic       tx_done,
   output logic [7:0] drop_cnt
);
   localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, FIELD = 3'd2, CS_HI = 3'd3,
                          CS_LO = 3'd4, WAIT_CR = 3'd5, WAIT_LF = 3'd6;
   localparam logic [1:0] R_IDLE = 2'd0, R_REQ = 2'd1, R_WAIT = 2'd2;
   logic [2:0] st_q, st_d, acnt_q, acnt_d;
   logic [7:0] csum_q, csum_d, fld_char_q, fld_char_d;
   logic [6:0] len_q, len_d;
   logic [3:0] idx_q, idx_d, cs_hi_q, cs_hi_d;
   logic       gll_q, gll_d, fld_dv_q, fld_dv_d, fld_end_q, fld_end_d;
   logic       ok_q, ok_d, err_q, err_d, fail;
   logic [1:0] rs_q, rs_d, bcnt_q, bcnt_d;
   logic       pend_q, pend_d, pend_ok_q, pend_ok_d, tx_dv_q, tx_dv_d, post, load;
   logic [7:0] tx_byte_q, tx_byte_d, drop_q, drop_d;
   logic       is_dig, is_hex;
   logic [3:0] hex_val;
   assign is_dig  = rx_byte >= 8'h30 && rx_byte <= 8'h39;
   assign is_hex  = is_dig || (rx_byte >= 8'h41 && rx_byte <= 8'h46);
   assign hex_val = is_dig ? rx_byte[3:0] : rx_byte[3:0] + 4'd9;
   always_comb begin
      st_d = st_q;
      csum_d = csum_q;
      len_d = len_q;
      idx_d = idx_q;
      acnt_d = acnt_q;
      gll_d = gll_q;
      cs_hi_d = cs_hi_q;
      fld_char_d = fld_char_q;
      fld_dv_d = 1'b0;
      fld_end_d = 1'b0;
      ok_d = 1'b0;
      err_d = 1'b0;
      fail = 1'b0;
      if (rx_dv) begin
         len_d = len_q + 7'd1;
         if (rx_byte == 8'h24) begin
            st_d = ADDR;
            csum_d = '0;
            len_d = 7'd1;
            idx_d = '0;
            acnt_d = '0;
            gll_d = 1'b1;
         end else if (st_q != IDLE && len_q >= 7'(MAX_LEN)) begin
            fail = 1'b1;
         end else begin
            case (st_q)
               ADDR: begin
                  csum_d = csum_q ^ rx_byte;
                  fld_dv_d = 1'b1;
                  fld_char_d = rx_byte;
                  acnt_d = acnt_q + 3'd1;
                  gll_d = gll_q & (acnt_q < 3'd2 || rx_byte == (acnt_q == 3'd2 ? 8'h47 : 8'h4C));
                  st_d = acnt_q == 3'd4 ? FIELD : ADDR;
               end
               FIELD: begin
                  if (rx_byte == 8'h2A) begin
                     fld_end_d = 1'b1;
                     st_d = CS_HI;
                  end else if (rx_byte == 8'h2C) begin
                     csum_d = csum_q ^ rx_byte;
                     fail = idx_q == 4'(MAX_FIELDS);
                     fld_end_d = !fail;
                     idx_d = fail ? idx_q : idx_q + 4'd1;
                  end else begin
                     csum_d = csum_q ^ rx_byte;
                     fld_dv_d = 1'b1;
                     fld_char_d = rx_byte;
                  end
               end
               CS_HI: begin
                  cs_hi_d = hex_val;
                  fail = !is_hex;
                  st_d = CS_LO;
               end
               CS_LO: begin
                  fail = !is_hex || {cs_hi_q, hex_val} != csum_q;
                  st_d = WAIT_CR;
               end
               WAIT_CR: begin
                  fail = rx_byte != 8'h0D;
                  st_d = WAIT_LF;
               end
               WAIT_LF: begin
                  fail = rx_byte != 8'h0A;
                  ok_d = gll_q & !fail;
                  st_d = IDLE;
               end
               default: ;
            endcase
         end
         if (fail) begin
            st_d = IDLE;
            err_d = gll_q;
         end
      end
   end
   // The reporter frees the pending slot in the same cycle a new result may land in it.
   always_comb begin
      post = ok_q | err_q;
      load = rs_q == R_IDLE && pend_q;
      pend_d = post | (pend_q & ~load);
      pend_ok_d = post ? ok_q : pend_ok_q;
      drop_d = (post && pend_q && !load && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      rs_d = rs_q;
      bcnt_d = bcnt_q;
      tx_byte_d = tx_byte_q;
      tx_dv_d = 1'b0;
      case (rs_q)
         R_IDLE: if (pend_q) begin
            bcnt_d = '0;
            tx_byte_d = pend_ok_q ? 8'h41 : 8'h4E;
            tx_dv_d = ~tx_active;
            rs_d = tx_active ? R_REQ : R_WAIT;
         end
         R_REQ: begin
            tx_dv_d = ~tx_active;
            rs_d = tx_active ? R_REQ : R_WAIT;
         end
         R_WAIT: if (tx_done) begin
            if (bcnt_q == 2'd3) begin
               rs_d = R_IDLE;
            end else begin
               bcnt_d = bcnt_q + 2'd1;
               tx_byte_d = bcnt_q == 2'd0 ? 8'h4B : bcnt_q == 2'd1 ? 8'h0D : 8'h0A;
               tx_dv_d = ~tx_active;
               rs_d = tx_active ? R_REQ : R_WAIT;
            end
         end
         default: rs_d = R_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q <= IDLE;
         csum_q <= '0;
         len_q <= '0;
         idx_q <= '0;
         acnt_q <= '0;
         gll_q <= 1'b0;
         cs_hi_q <= '0;
         fld_char_q <= '0;
         fld_dv_q <= 1'b0;
         fld_end_q <= 1'b0;
         ok_q <= 1'b0;
         err_q <= 1'b0;
         rs_q <= R_IDLE;
         bcnt_q <= '0;
         pend_q <= 1'b0;
         pend_ok_q <= 1'b0;
         tx_dv_q <= 1'b0;
         tx_byte_q <= '0;
         drop_q <= '0;
      end else begin
         st_q <= st_d;
         csum_q <= csum_d;
         len_q <= len_d;
         idx_q <= idx_d;
         acnt_q <= acnt_d;
         gll_q <= gll_d;
         cs_hi_q <= cs_hi_d;
         fld_char_q <= fld_char_d;
         fld_dv_q <= fld_dv_d;
         fld_end_q <= fld_end_d;
         ok_q <= ok_d;
         err_q <= err_d;
         rs_q <= rs_d;
         bcnt_q <= bcnt_d;
         pend_q <= pend_d;
         pend_ok_q <= pend_ok_d;
         tx_dv_q <= tx_dv_d;
         tx_byte_q <= tx_byte_d;
         drop_q <= drop_d;
      end
   end
   assign fld_dv    = fld_dv_q;
   assign fld_char  = fld_char_q;
   assign fld_idx   = idx_q;
   assign fld_end   = fld_end_q;
   assign frame_ok  = ok_q;
   assign frame_err = err_q;
   assign tx_dv     = tx_dv_q;
   assign tx_byte   = tx_byte_q;
   assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_nmea_frame_ctrl.sv
// tb_nmea_frame_ctrl: directed sentences against nmea_frame_ctrl with a simple UART transmitter responder
module tb_nmea_frame_ctrl;
   logic       clk = 1'b0, rst = 1'b1, rx_dv = 1'b0, hold = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       fld_dv, fld_end, frame_ok, frame_err, tx_dv, tx_active, tx_done;
   logic [7:0] fld_char, tx_byte, drop_cnt;
   logic [3:0] fld_idx;
   int         vecs = 0, errs = 0, ok_cnt = 0, err_cnt = 0, end_cnt = 0;
   logic [11:0] fldq[$];
   logic [7:0]  txq[$];
   string       valid = "$GPGLL,,,,,,A*11";

   nmea_frame_ctrl dut (
      .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
      .fld_dv(fld_dv), .fld_char(fld_char), .fld_idx(fld_idx), .fld_end(fld_end),
      .frame_ok(frame_ok), .frame_err(frame_err), .tx_dv(tx_dv), .tx_byte(tx_byte),
      .tx_active(tx_active), .tx_done(tx_done), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin : xmtr
      int cnt;
      cnt = 0;
      tx_active = 1'b0;
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (rst) tx_active = 1'b0;
         else if (tx_dv) begin
            txq.push_back(tx_byte);
            tx_active = 1'b1;
            cnt = 3;
         end else if (tx_active && !hold) begin
            if (cnt == 0) begin
               tx_active = 1'b0;
               tx_done = 1'b1;
            end else cnt--;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (fld_dv) fldq.push_back({fld_idx, fld_char});
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
      if (fld_end) end_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clr;
      ok_cnt = 0;
      err_cnt = 0;
      end_cnt = 0;
      fldq.delete();
      txq.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_dv = 1'b1;
      rx_byte = b;
      @(posedge clk);
      #1 rx_dv = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic send_crlf;
      send_byte(8'h0D);
      send_byte(8'h0A);
   endtask

   task automatic wait_tx(input int n);
      for (int i = 0; i < 400 && txq.size() < n; i++) idle(1);
      chk("tx_count", txq.size(), n);
   endtask

   initial begin
      idle(4);
      chk("rst_fld_dv", fld_dv, 1'b0);
      chk("rst_fld_end", fld_end, 1'b0);
      chk("rst_results", {frame_ok, frame_err}, 2'b00);
      chk("rst_tx_dv", tx_dv, 1'b0);
      chk("rst_fld_idx", fld_idx, 4'd0);
      chk("rst_tx_byte", tx_byte, 8'h00);
      chk("rst_drop", drop_cnt, 8'h00);
      rst = 1'b0;
      idle(2);

      clr();
      send_str(valid);
      send_crlf();
      chk("ok_pulse_timing", frame_ok, 1'b1);
      idle(1);
      chk("tx_dv_early", tx_dv, 1'b0);
      idle(1);
      chk("tx_dv_first", tx_dv, 1'b1);
      chk("tx_byte_first", tx_byte, 8'h41);
      wait_tx(4);
      idle(20);
      chk("ok_count", ok_cnt, 1);
      chk("err_count", err_cnt, 0);
      chk("tx0", txq[0], 8'h41);
      chk("tx1", txq[1], 8'h4B);
      chk("tx2", txq[2], 8'h0D);
      chk("tx3", txq[3], 8'h0A);
      chk("fld_entries", fldq.size(), 6);
      chk("fld_addr0", fldq[0], 12'h047);
      chk("fld_A_idx6", fldq[5], 12'h641);
      chk("fld_end_count", end_cnt, 7);

      clr();
      send_str("$GPGLL,1234.56,N,9876.54,E,122519,A*00");
      send_crlf();
      wait_tx(4);
      idle(20);
      chk("bad_cs_err", err_cnt, 1);
      chk("bad_cs_ok", ok_cnt, 0);
      chk("nk0", txq[0], 8'h4E);
      chk("nk1", txq[1], 8'h4B);
      chk("nk2", txq[2], 8'h0D);
      chk("nk3", txq[3], 8'h0A);
      chk("fld2_N", fldq[12], 12'h24E);
      chk("fld4_E", fldq[20], 12'h445);

      clr();
      send_str("$GPGGA,,*..");
      send_crlf();
      idle(20);
      chk("gga_results", ok_cnt + err_cnt, 0);
      chk("gga_tx", txq.size(), 0);
      send_str(valid);
      send_crlf();
      wait_tx(4);
      idle(20);
      chk("after_gga_ok", ok_cnt, 1);
      chk("after_gga_ak", txq[0], 8'h41);

      clr();
      send_str("$GPG");
      send_str(valid);
      send_crlf();
      wait_tx(4);
      idle(20);
      chk("restart_ok", ok_cnt, 1);
      chk("restart_err", err_cnt, 0);
      chk("restart_ak", txq[0], 8'h41);

      clr();
      hold = 1'b1;
      repeat (3) begin
         send_str(valid);
         send_crlf();
      end
      idle(10);
      chk("b2b_ok", ok_cnt, 3);
      chk("b2b_drop", drop_cnt, 8'd1);
      chk("b2b_tx_held", txq.size(), 1);
      hold = 1'b0;
      wait_tx(8);
      idle(20);
      chk("b2b_first_a", txq[0], 8'h41);
      chk("b2b_second_a", txq[4], 8'h41);
      chk("b2b_second_k", txq[5], 8'h4B);
      chk("b2b_second_lf", txq[7], 8'h0A);
      chk("b2b_drop_hold", drop_cnt, 8'd1);

      clr();
      send_str("$GPGLL");
      for (int i = 0; i < 76; i++) send_byte(8'h58);
      chk("len82_no_err", err_cnt, 0);
      send_byte(8'h58);
      chk("len83_err", frame_err, 1'b1);
      wait_tx(2);
      chk("ovf_n", txq[0], 8'h4E);
      chk("ovf_k", txq[1], 8'h4B);
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(60);
      chk("rst_no_more_tx", txq.size(), 2);
      chk("rst_tx_byte_clr", tx_byte, 8'h00);
      chk("rst_drop_clr", drop_cnt, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
